// File: rtl/dm_access_ctrl_pkg.sv
// dm_access_ctrl_pkg: shared encodings for the M-stage data-memory access
// controller (access widths, FSM states, exception codes).
package dm_access_ctrl_pkg;

    // Access width encodings carried on op / ld_op.
    localparam logic [2:0] OP_WORD = 3'b000;
    localparam logic [2:0] OP_HALF = 3'b010;
    localparam logic [2:0] OP_BYTE = 3'b100;

    // Access FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Exception codes reported on exc_code.
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Address-error code for a misaligned access: store vs load.
    function automatic logic [4:0] adr_exc_code(input logic is_store);
        return is_store ? EXC_ADES : EXC_ADEL;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_st_align.sv
// st_align: combinational lane steering for a load/store. Produces the byte
// enables (zero for loads), the lane-replicated store data and the alignment
// error flag. Unknown op codes behave as word accesses.
module st_align
    import dm_access_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [3:0]  byteen,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    // Decode width into enables, replicated lanes and alignment check.
    always_comb begin
        byteen     = 4'b0000;
        lane_data  = wdata;
        misaligned = 1'b0;
        case (op)
            OP_HALF: begin
                lane_data  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
                if (we) begin
                    byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
                end else begin
                    byteen = 4'b0000;
                end
            end
            OP_BYTE: begin
                lane_data  = {4{wdata[7:0]}};
                misaligned = 1'b0;
                if (we) begin
                    byteen = 4'b0001 << addr_lo;
                end else begin
                    byteen = 4'b0000;
                end
            end
            default: begin
                lane_data  = wdata;
                misaligned = (addr_lo != 2'b00);
                if (we) begin
                    byteen = 4'b1111;
                end else begin
                    byteen = 4'b0000;
                end
            end
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: M-stage data-memory access controller. Issues one
// word-aligned, byte-enabled request per aligned load/store, stalls the pipe
// until acknowledge, latches the raw read word for the load extender and
// flags misaligned accesses without issuing a request.
// Optional build macro DM_TIMEOUT_EN adds an acknowledge watchdog that ends a
// stuck request after TIMEOUT cycles with a bus-error exception.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        stall,
    output logic [31:0] rdata_q,
    output logic [1:0]  addr_lo,
    output logic [2:0]  ld_op,
    output logic        done,
    output logic        exc,
    output logic [4:0]  exc_code
);

    state_e      state_q, state_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [3:0]  m_byteen_q, m_byteen_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic [31:0] rdata_d;

    logic [3:0]  al_byteen_s;
    logic [31:0] al_wdata_s;
    logic        al_misaligned_s;

`ifdef DM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 32'd255) ? $clog2(TIMEOUT + 32'd1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbe_q, dbe_d;
    logic             timeout_s;
    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT - 32'd1));
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT == 32'd0);
`endif

    st_align u_st_align (
        .op         (op),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .we         (we),
        .byteen     (al_byteen_s),
        .lane_data  (al_wdata_s),
        .misaligned (al_misaligned_s)
    );

    // Next-state logic: launch aligned accesses, wait for ack (or watchdog).
    always_comb begin
        state_d    = state_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_byteen_d = m_byteen_q;
        m_wdata_d  = m_wdata_q;
        addr_lo_d  = addr_lo_q;
        ld_op_d    = ld_op_q;
        rdata_d    = rdata_q;
`ifdef DM_TIMEOUT_EN
        cnt_d      = cnt_q;
        dbe_d      = dbe_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en && !al_misaligned_s) begin
                    state_d    = ST_REQ;
                    m_we_d     = we;
                    m_addr_d   = {addr[31:2], 2'b00};
                    m_byteen_d = al_byteen_s;
                    m_wdata_d  = al_wdata_s;
                    addr_lo_d  = addr[1:0];
                    ld_op_d    = op;
`ifdef DM_TIMEOUT_EN
                    cnt_d      = '0;
                    dbe_d      = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
`ifdef DM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (m_ack) begin
                    state_d = ST_DONE;
                    rdata_d = m_rdata;
                end
`ifdef DM_TIMEOUT_EN
                else if (timeout_s) begin
                    state_d = ST_DONE;
                    rdata_d = 32'd0;
                    dbe_d   = 1'b1;
                end
`endif
                else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                // en here belongs to the instruction that just completed.
                state_d = ST_IDLE;
`ifdef DM_TIMEOUT_EN
                dbe_d   = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_byteen_q <= 4'b0000;
            m_wdata_q  <= 32'd0;
            addr_lo_q  <= 2'b00;
            ld_op_q    <= 3'b000;
            rdata_q    <= 32'd0;
`ifdef DM_TIMEOUT_EN
            cnt_q      <= '0;
            dbe_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_byteen_q <= m_byteen_d;
            m_wdata_q  <= m_wdata_d;
            addr_lo_q  <= addr_lo_d;
            ld_op_q    <= ld_op_d;
            rdata_q    <= rdata_d;
`ifdef DM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            dbe_q      <= dbe_d;
`endif
        end
    end

    // Pipeline handshake and exception reporting.
    always_comb begin
        m_req    = (state_q == ST_REQ);
        done     = (state_q == ST_DONE);
        stall    = ((state_q == ST_IDLE) && en && !al_misaligned_s) || (state_q == ST_REQ);
        exc      = 1'b0;
        exc_code = 5'd0;
        if ((state_q == ST_IDLE) && en && al_misaligned_s) begin
            exc      = 1'b1;
            exc_code = adr_exc_code(we);
        end
`ifdef DM_TIMEOUT_EN
        else if ((state_q == ST_DONE) && dbe_q) begin
            exc      = 1'b1;
            exc_code = EXC_DBE;
        end
`endif
        else begin
            exc      = 1'b0;
            exc_code = 5'd0;
        end
    end

    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_byteen = m_byteen_q;
    assign m_wdata  = m_wdata_q;
    assign addr_lo  = addr_lo_q;
    assign ld_op    = ld_op_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed scenarios plus randomized transactions checked
// against a width/alignment reference model. Define DM_TIMEOUT_EN to also
// exercise the acknowledge watchdog (instance built with TIMEOUT=4).
module tb_dm_access_ctrl;

    localparam int unsigned TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_req, m_we, stall, done, exc;
    logic [31:0] m_addr, m_wdata, rdata_q;
    logic [3:0]  m_byteen;
    logic [1:0]  addr_lo;
    logic [2:0]  ld_op;
    logic [4:0]  exc_code;

    int n_checks = 0;
    int n_errors = 0;

    dm_access_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .en(en), .we(we), .op(op), .addr(addr),
        .wdata(wdata), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_byteen(m_byteen), .m_wdata(m_wdata), .m_ack(m_ack),
        .m_rdata(m_rdata), .stall(stall), .rdata_q(rdata_q),
        .addr_lo(addr_lo), .ld_op(ld_op), .done(done), .exc(exc),
        .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Reference model: access size in bytes (unknown codes are words).
    function automatic int acc_size(input logic [2:0] o);
        if (o == 3'b010) return 2;
        if (o == 3'b100) return 1;
        return 4;
    endfunction

    function automatic bit model_aligned(input logic [2:0] o, input logic [31:0] a);
        return (a % acc_size(o)) == 0;
    endfunction

    function automatic logic [3:0] model_byteen(input logic [2:0] o, input logic [31:0] a, input logic w);
        logic [7:0] m;
        if (!w) return 4'b0000;
        m = ((8'd1 << acc_size(o)) - 8'd1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_lanes(input logic [2:0] o, input logic [31:0] d);
        if (acc_size(o) == 2) return (d & 32'h0000FFFF) * 32'h00010001;
        if (acc_size(o) == 1) return (d & 32'h000000FF) * 32'h01010101;
        return d;
    endfunction

    task automatic test_reset;
        reset = 1'b0; en = 1'b0; m_ack = 1'b0;
        tick; tick;
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_errors++; $display("FAIL rst_m_req: got %b exp 0", m_req); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b exp 0", done); end
        n_checks++; if ({m_we, m_addr, m_byteen, m_wdata, rdata_q, addr_lo, ld_op} !== 106'd0) begin
            n_errors++; $display("FAIL rst_regs: got %h %h %h %h %h %h %h exp all 0", m_we, m_addr, m_byteen, m_wdata, rdata_q, addr_lo, ld_op);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_store_byte;
        int nst;
        en = 1'b1; we = 1'b1; op = 3'b100; addr = 32'h13; wdata = 32'h000000AB;
        #1;
        nst = int'(stall);
        tick;
        en = 1'b0;
        #1;
        nst += int'(stall);
        n_checks++; if (m_req !== 1'b1) begin n_errors++; $display("FAIL sb_m_req: got %b exp 1", m_req); end
        n_checks++; if (m_byteen !== 4'b1000) begin n_errors++; $display("FAIL sb_byteen: got %b exp 1000", m_byteen); end
        n_checks++; if (m_wdata !== 32'hABABABAB) begin n_errors++; $display("FAIL sb_wdata: got %h exp ababab ab", m_wdata); end
        n_checks++; if (m_addr !== 32'h10) begin n_errors++; $display("FAIL sb_addr: got %h exp 10", m_addr); end
        n_checks++; if (m_we !== 1'b1) begin n_errors++; $display("FAIL sb_we: got %b exp 1", m_we); end
        m_ack = 1'b1; m_rdata = 32'h0BAD0BAD;
        tick;
        m_ack = 1'b0;
        #1;
        nst += int'(stall);
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL sb_done: got %b exp 1", done); end
        n_checks++; if (nst != 2) begin n_errors++; $display("FAIL sb_stall_cycles: got %0d exp 2", nst); end
        tick;
    endtask

    task automatic test_load_half;
        int nst;
        en = 1'b1; we = 1'b0; op = 3'b010; addr = 32'h22; wdata = 32'hFFFFFFFF;
        #1;
        nst = int'(stall);
        tick;
        en = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin m_ack = 1'b1; m_rdata = 32'h80017FFF; end
            #1;
            nst += int'(stall);
            if (c == 1) begin
                n_checks++; if (m_byteen !== 4'b0000) begin n_errors++; $display("FAIL lh_byteen: got %b exp 0000", m_byteen); end
                n_checks++; if (m_addr !== 32'h20) begin n_errors++; $display("FAIL lh_addr: got %h exp 20", m_addr); end
            end
            tick;
        end
        m_ack = 1'b0;
        #1;
        nst += int'(stall);
        n_checks++; if (nst != 4) begin n_errors++; $display("FAIL lh_stall_cycles: got %0d exp 4", nst); end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL lh_done: got %b exp 1", done); end
        n_checks++; if (rdata_q !== 32'h80017FFF) begin n_errors++; $display("FAIL lh_rdata: got %h exp 80017fff", rdata_q); end
        n_checks++; if (addr_lo !== 2'd2) begin n_errors++; $display("FAIL lh_addr_lo: got %0d exp 2", addr_lo); end
        n_checks++; if (ld_op !== 3'b010) begin n_errors++; $display("FAIL lh_ld_op: got %b exp 010", ld_op); end
        tick;
    endtask

    task automatic test_misaligned;
        en = 1'b1; we = 1'b1; op = 3'b000; addr = 32'h06; wdata = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (exc !== 1'b1) begin n_errors++; $display("FAIL mis_exc: got %b exp 1", exc); end
            n_checks++; if (exc_code !== 5'd5) begin n_errors++; $display("FAIL mis_code: got %0d exp 5", exc_code); end
            n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL mis_stall: got %b exp 0", stall); end
            n_checks++; if (m_req !== 1'b0) begin n_errors++; $display("FAIL mis_m_req: got %b exp 0", m_req); end
            tick;
        end
        we = 1'b0; op = 3'b010; addr = 32'h41;
        #1;
        n_checks++; if (exc_code !== 5'd4 || exc !== 1'b1) begin n_errors++; $display("FAIL mis_load_code: got %b/%0d exp 1/4", exc, exc_code); end
        en = 1'b0;
        tick;
        #1;
        n_checks++; if (m_req !== 1'b0 || exc !== 1'b0) begin n_errors++; $display("FAIL mis_after: got req %b exc %b exp 0 0", m_req, exc); end
        tick;
    endtask

    task automatic test_en_through_done;
        int reqs;
        en = 1'b1; we = 1'b1; op = 3'b100; addr = 32'h05; wdata = 32'h0000005A;
        tick;
        #1;
        reqs = int'(m_req);
        m_ack = 1'b1;
        tick;
        m_ack = 1'b0;
        #1;
        reqs += int'(m_req);
        n_checks++; if (done !== 1'b1 || stall !== 1'b0) begin n_errors++; $display("FAIL etd_done: got done %b stall %b exp 1 0", done, stall); end
        tick;
        #1;
        n_checks++; if (reqs != 1 || m_req !== 1'b0) begin n_errors++; $display("FAIL etd_reqs: got %0d req %b exp 1 0", reqs, m_req); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL etd_idle_stall: got %b exp 1", stall); end
        tick;
        en = 1'b0;
        #1;
        n_checks++; if (m_req !== 1'b1 || m_byteen !== 4'b0010) begin n_errors++; $display("FAIL etd_second: got req %b be %b exp 1 0010", m_req, m_byteen); end
        m_ack = 1'b1;
        tick;
        m_ack = 1'b0;
        tick;
    endtask

    task automatic test_reset_in_req;
        en = 1'b1; we = 1'b0; op = 3'b000; addr = 32'h40;
        tick;
        en = 1'b0;
        #1;
        n_checks++; if (m_req !== 1'b1) begin n_errors++; $display("FAIL rr_req_before: got %b exp 1", m_req); end
        reset = 1'b0; m_ack = 1'b1; m_rdata = 32'h12345678;
        tick;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (m_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL rr_state: got req %b done %b stall %b exp 0 0 0", m_req, done, stall); end
            n_checks++; if (rdata_q !== 32'd0 || m_addr !== 32'd0) begin n_errors++; $display("FAIL rr_regs: got rdata %h addr %h exp 0 0", rdata_q, m_addr); end
            tick;
        end
        m_ack = 1'b0;
        tick;
    endtask

`ifdef DM_TIMEOUT_EN
    task automatic test_timeout;
        en = 1'b1; we = 1'b0; op = 3'b000; addr = 32'h100;
        tick;
        en = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_checks++; if (m_req !== 1'b1 || exc !== 1'b0) begin n_errors++; $display("FAIL to_req%0d: got req %b exc %b exp 1 0", c, m_req, exc); end
            tick;
        end
        #1;
        n_checks++; if (done !== 1'b1 || exc !== 1'b1 || exc_code !== 5'd7) begin n_errors++; $display("FAIL to_done: got done %b exc %b code %0d exp 1 1 7", done, exc, exc_code); end
        n_checks++; if (rdata_q !== 32'd0) begin n_errors++; $display("FAIL to_rdata: got %h exp 0", rdata_q); end
        tick;
        #1;
        n_checks++; if (exc !== 1'b0) begin n_errors++; $display("FAIL to_exc_clear: got %b exp 0", exc); end
        // Ack in the timeout cycle wins.
        en = 1'b1;
        tick;
        en = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin m_ack = 1'b1; m_rdata = 32'hCAFEF00D; end
            tick;
        end
        m_ack = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1 || exc !== 1'b0 || rdata_q !== 32'hCAFEF00D) begin n_errors++; $display("FAIL to_ack_wins: got done %b exc %b rdata %h exp 1 0 cafef00d", done, exc, rdata_q); end
        tick;
    endtask
`endif

    task automatic test_random;
        logic [2:0]  ops [11] = '{3'b000, 3'b010, 3'b100, 3'b000, 3'b010, 3'b100, 3'b001, 3'b011, 3'b101, 3'b110, 3'b111};
        logic [31:0] rd;
        int          dly;
        for (int t = 0; t < 60; t++) begin
            en = 1'b1; we = 1'($urandom_range(0, 1)); op = ops[$urandom_range(0, 10)];
            addr = $urandom; wdata = $urandom; rd = $urandom; m_ack = 1'b0;
            #1;
            if (!model_aligned(op, addr)) begin
                n_checks++; if (exc !== 1'b1 || exc_code !== (we ? 5'd5 : 5'd4) || stall !== 1'b0 || m_req !== 1'b0) begin
                    n_errors++; $display("FAIL rnd%0d_mis: got exc %b code %0d stall %b req %b", t, exc, exc_code, stall, m_req);
                end
                tick;
                en = 1'b0;
                #1;
                n_checks++; if (m_req !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_mis_idle: got req %b done %b exp 0 0", t, m_req, done); end
                tick;
            end else begin
                n_checks++; if (stall !== 1'b1 || exc !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_start: got stall %b exc %b exp 1 0", t, stall, exc); end
                tick;
                en = 1'($urandom_range(0, 1));
                dly = $urandom_range(0, 3);
                for (int k = 0; k <= dly; k++) begin
                    if (k == dly) begin m_ack = 1'b1; m_rdata = rd; end
                    #1;
                    n_checks++; if (m_req !== 1'b1 || stall !== 1'b1 || m_we !== we) begin n_errors++; $display("FAIL rnd%0d_req: got req %b stall %b we %b", t, m_req, stall, m_we); end
                    n_checks++; if (m_addr !== (addr & 32'hFFFFFFFC)) begin n_errors++; $display("FAIL rnd%0d_addr: got %h exp %h", t, m_addr, addr & 32'hFFFFFFFC); end
                    n_checks++; if (m_byteen !== model_byteen(op, addr, we)) begin n_errors++; $display("FAIL rnd%0d_byteen: got %b exp %b", t, m_byteen, model_byteen(op, addr, we)); end
                    n_checks++; if (m_wdata !== model_lanes(op, wdata)) begin n_errors++; $display("FAIL rnd%0d_wdata: got %h exp %h", t, m_wdata, model_lanes(op, wdata)); end
                    tick;
                end
                m_ack = 1'($urandom_range(0, 1)); m_rdata = $urandom; en = 1'($urandom_range(0, 1));
                #1;
                n_checks++; if (done !== 1'b1 || stall !== 1'b0 || m_req !== 1'b0 || exc !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_done: got done %b stall %b req %b exc %b", t, done, stall, m_req, exc); end
                n_checks++; if (rdata_q !== rd || addr_lo !== addr[1:0] || ld_op !== op) begin n_errors++; $display("FAIL rnd%0d_latch: got %h %0d %b exp %h %0d %b", t, rdata_q, addr_lo, ld_op, rd, addr[1:0], op); end
                tick;
                en = 1'b0; m_ack = 1'b0;
                #1;
                n_checks++; if (done !== 1'b0 || m_req !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_idle: got done %b req %b stall %b exp 0 0 0", t, done, m_req, stall); end
                tick;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_en_through_done();
        test_reset_in_req();
`ifdef DM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Memory-stage data-memory access controller for the pipelined MIPS core. Turns a load/store request from the M stage into a byte-enabled, word-aligned request/acknowledge transaction towards data memory or the bus bridge. Stalls the pipeline until the access completes and holds the raw read word for the downstream load extender. That extender consumes `rdata_q`, `addr_lo` and `ld_op`. Misaligned accesses are detected and reported without issuing a request.

## Interface
Parameters:
- `TIMEOUT`, 255: acknowledge watchdog limit in cycles; used only when `DM_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `en` in 1: M stage holds a load/store this cycle.
- `we` in 1: 1 = store, 0 = load.
- `op` in 3: access width; 000 word, 010 half, 100 byte. Other codes are treated as word.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `m_req` out 1: memory request.
- `m_we` out 1: memory write.
- `m_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `m_byteen` out 4: byte enables.
- `m_wdata` out 32: lane-shifted store data.
- `m_ack` in 1: memory acknowledge.
- `m_rdata` in 32: memory read word, valid with `m_ack`.
- `stall` out 1: freeze F/D/E/M stages.
- `rdata_q` out 32: latched raw read word.
- `addr_lo` out 2: latched `addr[1:0]`.
- `ld_op` out 3: latched `op`.
- `done` out 1: one-cycle completion pulse.
- `exc` out 1: exception flag.
- `exc_code` out 5: 4 AdEL, 5 AdES, 7 DBE.

## Operation
- FSM states and transitions:
  - IDLE → REQ when `en` and the access is aligned.
  - REQ → DONE on `m_ack`.
  - DONE → IDLE unconditionally.
- Alignment rules:
  - half requires `addr[0]=0`.
  - word requires `addr[1:0]=0`.
  - byte is always aligned.
- Misaligned access while in IDLE with `en`:
  - `exc`=1 combinationally that cycle, with `exc_code` 4 for a load and 5 for a store.
  - No request is issued, `stall` is 0, and the FSM stays in IDLE.
- Byte enables:
  - word: 1111.
  - half: `addr[1]` ? 1100 : 0011.
  - byte: `0001 << addr[1:0]`.
- `m_wdata`:
  - word: `wdata`.
  - half: `{2{wdata[15:0]}}`.
  - byte: `{4{wdata[7:0]}}`.
- `m_byteen` is 0000 for loads.
- On IDLE→REQ, the block registers `m_we`, `m_addr`, `m_byteen`, `m_wdata`, `ld_op` and `addr_lo`. They hold until leaving REQ.
- `m_req`=1 exactly while in REQ.
- On `m_ack` in REQ, `rdata_q` is loaded with `m_rdata`; this happens for stores as well, where the value is don't-care downstream. `rdata_q` holds until the next ack.
- `stall` = (IDLE & `en` & aligned) | REQ. It is 0 in DONE.
- `done`=1 exactly while in DONE.
- `en` is ignored in DONE, because it belongs to the instruction that just completed.
- `m_ack` is ignored in IDLE and DONE.

## Timing
- Cycle 0: IDLE, `en`, `stall`=1.
- Cycle 1: REQ, `m_req`=1.
- The earliest ack arrives in cycle 1, giving DONE in cycle 2 with `rdata_q` valid and `stall`=0. Minimum latency is 2 stall cycles.
- Each extra cycle without `m_ack` extends REQ and `stall` by one.
- Reset (`reset`=0 at an edge):
  - FSM returns to IDLE.
  - All registered outputs clear to 0: `m_req`, `m_we`, `m_addr`, `m_byteen`, `m_wdata`, `rdata_q`, `addr_lo`, `ld_op`, watchdog count.
  - `done`=0; `stall`=0 unless `en` is asserted.
- Reset in REQ drops `m_req` at that edge; a later `m_ack` is ignored.

## Configuration
- `DM_TIMEOUT_EN` defined:
  - An 8-bit+ counter clears on entering REQ and increments each REQ cycle.
  - If it reaches `TIMEOUT` without `m_ack`, the FSM moves to DONE with `rdata_q`=0, and `exc`=1 with `exc_code`=7 for that DONE cycle.
  - If ack and timeout occur in the same cycle, ack wins.
- `DM_TIMEOUT_EN` undefined: no counter, and REQ waits indefinitely.

## Structure
- Shared package holds:
  - op encodings: `OP_WORD`=000, `OP_HALF`=010, `OP_BYTE`=100.
  - FSM state encoding: IDLE, REQ, DONE.
  - exception codes: `EXC_ADEL`=4, `EXC_ADES`=5, `EXC_DBE`=7.
- One combinational sub-module, `st_align`: inputs `op`, `addr[1:0]`, `wdata`, `we`; outputs `byteen`, lane data, `misaligned`.

## Test plan
- Store byte: `wdata`=0x000000AB, `addr`=0x13, `m_ack` in the first REQ cycle → `m_byteen`=1000, `m_wdata`=0xABABABAB, `m_addr`=0x10, 2 stall cycles, `done` in cycle 2.
- Load half: `addr`=0x22, `m_rdata`=0x8001_7FFF, ack delayed 3 cycles → `m_byteen`=0000, `stall` high 4 cycles, `rdata_q`=0x80017FFF, `addr_lo`=2, `ld_op`=010.
- Misaligned store word at `addr`=0x06 → `exc`=1, `exc_code`=5, `m_req` never asserted, `stall`=0.
- `en` held high through DONE → exactly one request issued; the next access starts only from IDLE.
- Reset asserted in REQ, then `m_ack`=1 → next cycle IDLE, `m_req`=0, `rdata_q`=0, `done` never pulses.
- With `DM_TIMEOUT_EN`, `TIMEOUT`=4, and no ack → DONE after 4 REQ cycles, `exc_code`=7, `rdata_q`=0.
